// File: rtl/hbf_decim_scaler.sv
// hbf_decim_scaler: 2:1 decimator for a half-band filter output. Each kept
// sample is rounded, rescaled by 2^SHIFT and saturated to OUT_W bits, then
// staged for one cycle before entering a small first-word-fall-through FIFO.
// The block keeps a sticky saturation flag and a saturating drop counter for
// samples lost while the FIFO is full.
module hbf_decim_scaler #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8,
    parameter int SHIFT = 7,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [IN_W-1:0]          yIn,
    input  logic                     in_valid,
    input  logic                     clr,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     sat_flag,
    output logic [7:0]               drop_cnt
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = PTR_W + 1;

    // Rounding offset and clamp limits, all at the IN_W+1 working width.
    localparam logic signed [IN_W:0] ROUND_OFS = (IN_W+1)'(1) << (SHIFT - 1);
    localparam logic signed [IN_W:0] MAX_V     = (IN_W+1)'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [IN_W:0] MIN_V     = (IN_W+1)'(-(2 ** (OUT_W - 1)));
    localparam logic [FILL_W-1:0]    FULL_LVL  = FILL_W'(DEPTH);

    logic                    phase;
    logic                    keep;
    logic signed [IN_W:0]    biased;
    logic signed [IN_W:0]    shifted;
    logic [OUT_W-1:0]        scaled;
    logic                    sat_hit;

    logic [OUT_W-1:0]        s1_data;
    logic                    s1_valid;

    logic [OUT_W-1:0]        mem [DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic                    full;
    logic                    pop;
    logic                    push;
    logic                    drop;

    // The first valid sample after reset is kept, then every second one.
    assign keep = in_valid && !phase;

    // Sign-extend by one bit so adding the rounding offset cannot overflow.
    assign biased  = $signed({yIn[IN_W-1], yIn}) + ROUND_OFS;
    assign shifted = biased >>> SHIFT;

    // Clamp the rescaled value into the signed OUT_W range.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        scaled  = shifted[OUT_W-1:0];
        sat_hit = 1'b0;
        if (shifted > MAX_V) begin
            scaled  = MAX_V[OUT_W-1:0];
            sat_hit = 1'b1;
        end else if (shifted < MIN_V) begin
            scaled  = MIN_V[OUT_W-1:0];
            sat_hit = 1'b1;
        end
    end

    // Decimation phase: toggles on every valid input cycle.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            phase <= 1'b0;
        end else if (in_valid) begin
            phase <= ~phase;
        end
    end

    // One-cycle stage register between the scaler and the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= keep;
            if (keep) begin
                s1_data <= scaled;
            end
        end
    end

    assign out_valid = (fill != '0);
    assign full      = (fill == FULL_LVL);
    assign pop       = out_valid && out_ready;
    // A pop on the same edge frees a slot, so a full FIFO still accepts.
    assign push      = s1_valid && (!full || pop);
    assign drop      = s1_valid && full && !pop;

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fill <= fill + FILL_W'(1);
                2'b01:   fill <= fill - FILL_W'(1);
                default: fill <= fill;
            endcase
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; occupancy gates what is visible, so stale entries are never read.
        if (push) begin
            mem[wr_ptr] <= s1_data;
        end
    end

    // Head of the FIFO falls through; forced to zero when empty.
    assign out_data = out_valid ? mem[rd_ptr] : '0;

    // Sticky saturation flag; a new saturation wins over a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_flag <= 1'b0;
        end else if (keep && sat_hit) begin
            sat_flag <= 1'b1;
        end else if (clr) begin
            sat_flag <= 1'b0;
        end
    end

    // Saturating drop counter; a drop coinciding with clear restarts at one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop) begin
            if (clr) begin
                drop_cnt <= 8'd1;
            end else if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end else if (clr) begin
            drop_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_hbf_decim_scaler.sv
// tb_hbf_decim_scaler: directed scenarios plus randomized traffic, all
// compared every cycle against a transaction-level reference model built
// from a count of valid samples, a pending-sample queue and a FIFO queue.
module tb_hbf_decim_scaler;

    localparam int IN_W  = 16;
    localparam int OUT_W = 8;
    localparam int SHIFT = 7;
    localparam int DEPTH = 4;
    localparam int OMAX  = (2 ** (OUT_W - 1)) - 1;
    localparam int OMIN  = -(2 ** (OUT_W - 1));

    logic                   clk;
    logic                   rst;
    logic [IN_W-1:0]        yIn;
    logic                   in_valid;
    logic                   clr;
    logic [OUT_W-1:0]       out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [$clog2(DEPTH):0] fill;
    logic                   sat_flag;
    logic [7:0]             drop_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int fifo_q[$];
    int pend_q[$];
    int valid_count;
    int m_sat;
    int m_drop;

    hbf_decim_scaler #(
        .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .yIn(yIn), .in_valid(in_valid), .clr(clr),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .fill(fill), .sat_flag(sat_flag), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Round-half-up division by 2^SHIFT using floor division.
    function automatic int ref_scale(input int y);
        int d;
        int v;
        d = 1 << SHIFT;
        v = y + d / 2;
        if (v >= 0) return v / d;
        return -((-v + d - 1) / d);
    endfunction

    task automatic model_reset();
        fifo_q.delete();
        pend_q.delete();
        valid_count = 0;
        m_sat = 0;
        m_drop = 0;
    endtask

    // Advance the model by one clock edge using the inputs held over it.
    task automatic model_edge();
        bit pop;
        bit dropped;
        bit sat_ev;
        int r;
        pop = (fifo_q.size() > 0) && out_ready;
        dropped = 0;
        sat_ev = 0;
        if (pop) void'(fifo_q.pop_front());
        if (pend_q.size() > 0) begin
            r = pend_q.pop_front();
            if (fifo_q.size() < DEPTH) fifo_q.push_back(r);
            else dropped = 1;
        end
        if (in_valid) begin
            if (valid_count % 2 == 0) begin
                r = ref_scale(int'($signed(yIn)));
                if (r > OMAX) begin r = OMAX; sat_ev = 1; end
                if (r < OMIN) begin r = OMIN; sat_ev = 1; end
                pend_q.push_back(r);
            end
            valid_count++;
        end
        if (sat_ev) m_sat = 1;
        else if (clr) m_sat = 0;
        if (dropped) m_drop = clr ? 1 : (m_drop < 255 ? m_drop + 1 : 255);
        else if (clr) m_drop = 0;
    endtask

    task automatic compare_all();
        check("out_valid", int'(out_valid), (fifo_q.size() > 0) ? 1 : 0);
        check("fill", int'(fill), fifo_q.size());
        if (fifo_q.size() > 0) check("out_data", int'($signed(out_data)), fifo_q[0]);
        check("sat_flag", int'(sat_flag), m_sat);
        check("drop_cnt", int'(drop_cnt), m_drop);
    endtask

    task automatic step(input bit v, input int y, input bit rdy, input bit c);
        in_valid  = v;
        yIn       = 16'(y);
        out_ready = rdy;
        clr       = c;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_fill", int'(fill), 0);
        check("rst_out_data", int'(out_data), 0);
        rst = 1'b0;
        #1;
    endtask

    int impulse [7] = '{-128, 0, 2176, 4096, 2176, 0, -128};
    int gapped  [4] = '{128, 256, 384, 512};

    initial begin
        rst = 1'b1;
        yIn = '0;
        in_valid = 1'b0;
        clr = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #12;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_data", int'(out_data), 0);
        check("reset_fill", int'(fill), 0);
        check("reset_sat", int'(sat_flag), 0);
        check("reset_drop", int'(drop_cnt), 0);
        @(negedge clk);
        rst = 1'b0;

        // Impulse: outputs -1,17,17,-1, first two cycles after the first sample.
        for (int i = 0; i < 7; i++) begin
            step(1'b1, impulse[i], 1'b1, 1'b0);
            if (i == 1) check("imp_first", int'($signed(out_data)), -1);
            if (i == 3) check("imp_second", int'($signed(out_data)), 17);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1, 1'b0);
        check("imp_sat", int'(sat_flag), 0);

        // Saturation both ways, then clear.
        async_reset();
        step(1'b1, 32767, 1'b0, 1'b0);
        check("sat_set", int'(sat_flag), 1);
        step(1'b1, 0, 1'b0, 1'b0);
        check("sat_pos", int'($signed(out_data)), 127);
        step(1'b1, -32768, 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);
        check("sat_neg", int'($signed(out_data)), -128);
        step(1'b0, 0, 1'b1, 1'b1);
        check("sat_clr", int'(sat_flag), 0);

        // Backpressure: 20 valid inputs, 10 kept, 4 stored, 6 dropped.
        async_reset();
        for (int i = 0; i < 20; i++) step(1'b1, (i + 1) * 256, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0);
        check("bp_fill", int'(fill), 4);
        check("bp_drop", int'(drop_cnt), 6);
        check("bp_head", int'($signed(out_data)), 2);
        for (int i = 0; i < 5; i++) step(1'b0, 0, 1'b1, 1'b0);
        check("bp_drained", int'(fill), 0);

        // Full FIFO with a pending sample: push and pop on one edge.
        async_reset();
        for (int i = 0; i < 9; i++) step(1'b1, i * 128, 1'b0, 1'b0);
        check("full_pre", int'(fill), 4);
        step(1'b0, 0, 1'b1, 1'b0);
        check("full_fill", int'(fill), 4);
        check("full_drop", int'(drop_cnt), 0);
        for (int i = 0; i < 5; i++) step(1'b0, 0, 1'b1, 1'b0);

        // Gapped input: every second valid sample survives.
        async_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, gapped[i], 1'b0, 1'b0);
            step(1'b0, 0, 1'b0, 1'b0);
        end
        check("gap_fill", int'(fill), 2);
        check("gap_head", int'($signed(out_data)), 1);
        step(1'b0, 0, 1'b1, 1'b0);
        check("gap_second", int'($signed(out_data)), 3);

        // Reset mid-stream with three entries stored.
        async_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1000 + i, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0);
        check("mid_fill", int'(fill), 3);
        async_reset();
        step(1'b1, 640, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0);
        check("mid_after", int'($signed(out_data)), 5);

        // Randomized traffic with occasional clears and resets.
        for (int i = 0; i < 3000; i++) begin
            int y;
            case ($urandom_range(0, 3))
                0:       y = $urandom_range(0, 32767) - 16384;
                1:       y = $urandom_range(16000, 32767);
                2:       y = -$urandom_range(16000, 32768);
                default: y = $urandom_range(0, 512) - 256;
            endcase
            step($urandom_range(0, 3) != 0, y, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 39) == 0);
            if ($urandom_range(0, 499) == 0) async_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hbf_decim_scaler.md
HBF_DECIM_SCALER -- requirements
Module: hbf_decim_scaler

Interface
REQ-001 The block SHALL have parameter IN_W, default 16, input sample width (signed, two's complement).
REQ-002 The block SHALL have parameter OUT_W, default 8, output sample width (signed, two's complement).
REQ-003 The block SHALL have parameter SHIFT, default 7, right-shift rescale amount (filter coefficient sum 128 = 2^7).
REQ-004 The block SHALL have parameter DEPTH, default 4, output FIFO depth (power of two, >= 2).
REQ-005 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-006 The block SHALL have port rst, input, 1, reset; one clock; reset is asynchronous and active-high.
REQ-007 The block SHALL have port yIn, input, IN_W, filter output sample.
REQ-008 The block SHALL have port in_valid, input, 1, yIn is valid this cycle.
REQ-009 The block SHALL have port clr, input, 1, synchronous clear of sat_flag and drop_cnt.
REQ-010 The block SHALL have port out_data, output, OUT_W, FIFO head sample.
REQ-011 The block SHALL have port out_valid, output, 1, FIFO non-empty.
REQ-012 The block SHALL have port out_ready, input, 1, consumer accepts out_data when high with out_valid.
REQ-013 The block SHALL have port fill, output, log2(DEPTH)+1, FIFO occupancy.
REQ-014 The block SHALL have port sat_flag, output, 1, sticky saturation indicator.
REQ-015 The block SHALL have port drop_cnt, output, 8, saturating count of samples lost to FIFO full.

Function
REQ-016 Decimation: a 1-bit phase SHALL toggle on every clock with in_valid=1; a sample is kept only when phase=0 before the toggle, so the first valid sample after reset is kept, then every 2nd valid sample; cycles with in_valid=0 leave phase unchanged.
REQ-017 Rescale: a kept sample SHALL be computed at IN_W+1 bits as (yIn + 2^(SHIFT-1)) arithmetic-shifted right by SHIFT (round half up), with no intermediate overflow.
REQ-018 Saturation: the rescaled value SHALL be clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1] (-128..127 at default); any clamp SHALL set sat_flag on the next edge.
REQ-019 Pipeline: a kept sample SHALL be registered in one stage register (s1_data, s1_valid), then written into the FIFO on the following edge.
REQ-020 Latency: a kept sample presented in cycle k SHALL appear on out_data with out_valid=1 in cycle k+2 when the FIFO was empty.
REQ-021 FIFO SHALL be first-word-fall-through; out_data SHALL equal the oldest entry whenever out_valid=1; a pop occurs on an edge with out_valid=1 and out_ready=1.
REQ-022 Full: a write when fill=DEPTH and no pop on the same edge SHALL be discarded, FIFO content unchanged, and drop_cnt incremented (saturating at 255).
REQ-023 Simultaneous push and pop when full SHALL both succeed, fill unchanged, no drop.
REQ-024 Simultaneous push and pop when empty SHALL NOT occur (out_valid=0); the push succeeds, fill becomes 1.
REQ-025 FIFO pointers SHALL wrap modulo DEPTH; fill SHALL never exceed DEPTH nor go below 0.
REQ-026 out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-027 clr SHALL clear sat_flag and drop_cnt on the next edge; a simultaneous saturation or drop event on that edge SHALL take priority (sat_flag=1, drop_cnt=1).
REQ-028 sat_flag and drop_cnt SHALL be sticky until clr or rst.

Reset
REQ-029 While rst=1 phase, s1_valid, FIFO pointers, fill, sat_flag and drop_cnt SHALL be 0, out_valid=0 and out_data=0, immediately and without a clock edge.
REQ-030 Reset asserted mid-operation SHALL discard FIFO contents and the pending stage register; the first valid sample after deassertion is kept (phase=0).

Verification
REQ-031 Impulse: yIn = -128,0,2176,4096,2176,0,-128 on consecutive valid cycles, out_ready=1 -> outputs -1,17,17,-1 in order, first at cycle k+2, sat_flag=0.
REQ-032 Saturation: kept yIn=32767 -> out_data=127, sat_flag=1; kept yIn=-32768 -> out_data=-128; then clr pulse -> sat_flag=0.
REQ-033 Backpressure: out_ready=0, 20 continuous valid inputs (10 kept) -> fill=4, drop_cnt=6, out_data holds first kept sample; then out_ready=1 -> 4 samples drain in order, fill=0.
REQ-034 Full push/pop: FIFO full, out_ready=1 with kept sample arriving each edge -> fill stays 4, drop_cnt unchanged, order preserved.
REQ-035 Gapped input: in_valid toggling 1,0,1,0,... with yIn=128,256,384,512 on valid cycles -> outputs 1 and 3 only (every 2nd valid sample).
REQ-036 Reset mid-stream: rst pulsed asynchronously between edges with fill=3 -> out_valid=0, fill=0 immediately; next valid yIn=640 -> out_data=5 two cycles later.
